// File: rtl/mp_icache_ctrl_pkg.sv
// Shared state encoding, tag-entry layout and geometry helpers for the icache control responder.
package mp_icache_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_FLUSH_WALK,
    ST_FLUSH_DONE,
    ST_SEL_READ,
    ST_SEL_WRITE,
    ST_SEL_DONE
  } ctrl_state_e;

  function automatic int calc_set_w(input int nb_sets);
    return $clog2(nb_sets);
  endfunction

  function automatic int calc_off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int calc_tag_w(input int nb_sets, input int line_bytes);
    return 32 - $clog2(nb_sets) - $clog2(line_bytes);
  endfunction

  // Entry layout for the default 64-set / 16-byte-line geometry.
  localparam int DEF_TAG_W = calc_tag_w(64, 16);

  typedef struct packed {
    logic                 valid;
    logic [DEF_TAG_W-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/icache_stat_counters.sv
// Hit/transaction/miss counters of one icache bank; clear wins over increment, wraps mod 2^32.
module icache_stat_counters (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic        hit_i,
  input  logic        trans_i,
  input  logic        miss_i,
  output logic [31:0] hit_count_o,
  output logic [31:0] trans_count_o,
  output logic [31:0] miss_count_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_count_o   <= '0;
      trans_count_o <= '0;
      miss_count_o  <= '0;
    end else if (clear_i) begin
      hit_count_o   <= '0;
      trans_count_o <= '0;
      miss_count_o  <= '0;
    end else if (enable_i) begin
      if (hit_i)   hit_count_o   <= hit_count_o + 32'd1;
      if (trans_i) trans_count_o <= trans_count_o + 32'd1;
      if (miss_i)  miss_count_o  <= miss_count_o + 32'd1;
    end
  end

endmodule

// File: rtl/mp_icache_ctrl_responder.sv
// Cache-side responder of the icache control bus: bypass handshake, full/selective tag flush, statistics.
//   state         | meaning
//   ST_IDLE       | waiting for a flush or selective-flush request
//   ST_DRAIN      | stalling banks until every bank and the refill engine are idle
//   ST_FLUSH_WALK | invalidating all ways of one set per cycle
//   ST_FLUSH_DONE | full-flush ack held until the request drops
//   ST_SEL_READ   | reading the set of the latched address
//   ST_SEL_WRITE  | invalidating the matching ways, ack pulse
//   ST_SEL_DONE   | waiting for the selective request to drop
module mp_icache_ctrl_responder
  import mp_icache_ctrl_pkg::*;
#(
  parameter int NB_BANKS   = 4,
  parameter int NB_WAYS    = 4,
  parameter int NB_SETS    = 64,
  parameter int LINE_BYTES = 16,
  localparam int SET_W     = calc_set_w(NB_SETS),
  localparam int OFF_W     = calc_off_w(LINE_BYTES),
  localparam int TAG_W     = calc_tag_w(NB_SETS, LINE_BYTES)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              bypass_req_i,
  output logic [NB_BANKS:0]                 bypass_ack_o,
  input  logic [NB_BANKS-1:0]               bank_idle_i,
  input  logic                              refill_idle_i,
  input  logic                              flush_req_i,
  output logic                              flush_ack_o,
  input  logic                              sel_flush_req_i,
  input  logic [31:0]                       sel_flush_addr_i,
  output logic                              sel_flush_ack_o,
  output logic                              stall_o,
  output logic                              tag_req_o,
  output logic                              tag_we_o,
  output logic [SET_W-1:0]                  tag_addr_o,
  output logic [NB_WAYS-1:0]                tag_way_be_o,
  output logic [TAG_W:0]                    tag_wdata_o,
  input  logic [NB_WAYS-1:0][TAG_W:0]       tag_rdata_i,
  input  logic [NB_BANKS-1:0]               ctrl_clear_regs_i,
  input  logic [NB_BANKS-1:0]               ctrl_enable_regs_i,
  input  logic [NB_BANKS-1:0]               hit_i,
  input  logic [NB_BANKS-1:0]               trans_i,
  input  logic [NB_BANKS-1:0]               miss_i,
  output logic [NB_BANKS-1:0][31:0]         bank_hit_count_o,
  output logic [NB_BANKS-1:0][31:0]         bank_trans_count_o,
  output logic [NB_BANKS-1:0][31:0]         bank_miss_count_o,
  output logic [31:0]                       global_hit_count_o,
  output logic [31:0]                       global_trans_count_o,
  output logic [31:0]                       global_miss_count_o
);

  ctrl_state_e          state_q, state_d;
  logic [SET_W-1:0]     set_cnt_q, set_cnt_d;
  logic [31-OFF_W:0]    line_addr_q, line_addr_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [NB_BANKS:0]    bypass_q;
  logic [NB_BANKS:0]    idle_vec;
  logic [NB_WAYS-1:0]   hit_mask;
  logic [SET_W-1:0]     sel_set;
  logic [TAG_W-1:0]     sel_tag;
  logic [31:0]          hit_inc, trans_inc, miss_inc;
  logic                 unused_addr_bits;

  // Byte offset inside the line is irrelevant to invalidation.
  assign unused_addr_bits = ^sel_flush_addr_i[OFF_W-1:0];
  assign sel_set          = line_addr_q[SET_W-1:0];
  assign sel_tag          = line_addr_q[SET_W +: TAG_W];
  assign tag_wdata_o      = '0;
  assign idle_vec         = {refill_idle_i, bank_idle_i};
  assign bypass_ack_o     = bypass_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bypass_q <= '1;
    end else begin
      for (int b = 0; b <= NB_BANKS; b++) begin
        if (idle_vec[b]) bypass_q[b] <= bypass_req_i;
      end
    end
  end

  always_comb begin
    hit_mask = '0;
    for (int w = 0; w < NB_WAYS; w++) begin
      hit_mask[w] = tag_rdata_i[w][TAG_W] && (tag_rdata_i[w][TAG_W-1:0] == sel_tag);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      set_cnt_q    <= '0;
      line_addr_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      set_cnt_q    <= set_cnt_d;
      line_addr_q  <= line_addr_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    set_cnt_d       = set_cnt_q;
    line_addr_d     = line_addr_q;
    flush_pend_d    = flush_pend_q;
    stall_o         = 1'b0;
    flush_ack_o     = 1'b0;
    sel_flush_ack_o = 1'b0;
    tag_req_o       = 1'b0;
    tag_we_o        = 1'b0;
    tag_addr_o      = '0;
    tag_way_be_o    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (flush_req_i) begin
          state_d      = ST_DRAIN;
          flush_pend_d = 1'b1;
        end else if (sel_flush_req_i) begin
          state_d      = ST_DRAIN;
          flush_pend_d = 1'b0;
          line_addr_d  = sel_flush_addr_i[31:OFF_W];
        end
      end
      ST_DRAIN: begin
        stall_o = 1'b1;
        if (&bank_idle_i && refill_idle_i) begin
          set_cnt_d = '0;
          state_d   = flush_pend_q ? ST_FLUSH_WALK : ST_SEL_READ;
        end
      end
      ST_FLUSH_WALK: begin
        stall_o      = 1'b1;
        tag_req_o    = 1'b1;
        tag_we_o     = 1'b1;
        tag_way_be_o = '1;
        tag_addr_o   = set_cnt_q;
        set_cnt_d    = set_cnt_q + SET_W'(1);
        if (set_cnt_q == SET_W'(NB_SETS - 1)) state_d = ST_FLUSH_DONE;
      end
      ST_FLUSH_DONE: begin
        flush_ack_o = 1'b1;
        if (!flush_req_i) state_d = ST_IDLE;
      end
      ST_SEL_READ: begin
        stall_o    = 1'b1;
        tag_req_o  = 1'b1;
        tag_addr_o = sel_set;
        state_d    = ST_SEL_WRITE;
      end
      ST_SEL_WRITE: begin
        // Read data is valid here; a miss skips the write but still acks.
        stall_o         = 1'b1;
        tag_addr_o      = sel_set;
        tag_way_be_o    = hit_mask;
        tag_req_o       = |hit_mask;
        tag_we_o        = |hit_mask;
        sel_flush_ack_o = 1'b1;
        state_d         = ST_SEL_DONE;
      end
      ST_SEL_DONE: begin
        stall_o = 1'b1;
        if (!sel_flush_req_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank_stat
    icache_stat_counters u_stat (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .clear_i       (ctrl_clear_regs_i[b]),
      .enable_i      (ctrl_enable_regs_i[b]),
      .hit_i         (hit_i[b]),
      .trans_i       (trans_i[b]),
      .miss_i        (miss_i[b]),
      .hit_count_o   (bank_hit_count_o[b]),
      .trans_count_o (bank_trans_count_o[b]),
      .miss_count_o  (bank_miss_count_o[b])
    );
  end

  always_comb begin
    hit_inc   = '0;
    trans_inc = '0;
    miss_inc  = '0;
    for (int b = 0; b < NB_BANKS; b++) begin
      hit_inc   = hit_inc   + 32'(hit_i[b]   & ctrl_enable_regs_i[b]);
      trans_inc = trans_inc + 32'(trans_i[b] & ctrl_enable_regs_i[b]);
      miss_inc  = miss_inc  + 32'(miss_i[b]  & ctrl_enable_regs_i[b]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      global_hit_count_o   <= '0;
      global_trans_count_o <= '0;
      global_miss_count_o  <= '0;
    end else if (|ctrl_clear_regs_i) begin
      global_hit_count_o   <= '0;
      global_trans_count_o <= '0;
      global_miss_count_o  <= '0;
    end else begin
      global_hit_count_o   <= global_hit_count_o + hit_inc;
      global_trans_count_o <= global_trans_count_o + trans_inc;
      global_miss_count_o  <= global_miss_count_o + miss_inc;
    end
  end

endmodule

// File: tb/tb_mp_icache_ctrl_responder.sv
// Self-checking bench: tag-array memory model, bypass/flush/selective-flush scenarios, random statistics traffic.
module tb_mp_icache_ctrl_responder;

  localparam int NB_BANKS = 4, NB_WAYS = 4, NB_SETS = 64, LINE_BYTES = 16;
  localparam int SET_W = 6, OFF_W = 4, TAG_W = 22;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic bypass_req_i;
  logic [NB_BANKS:0] bypass_ack_o;
  logic [NB_BANKS-1:0] bank_idle_i;
  logic refill_idle_i;
  logic flush_req_i, flush_ack_o;
  logic sel_flush_req_i, sel_flush_ack_o;
  logic [31:0] sel_flush_addr_i;
  logic stall_o, tag_req_o, tag_we_o;
  logic [SET_W-1:0] tag_addr_o;
  logic [NB_WAYS-1:0] tag_way_be_o;
  logic [TAG_W:0] tag_wdata_o;
  logic [NB_WAYS-1:0][TAG_W:0] tag_rdata_i;
  logic [NB_BANKS-1:0] ctrl_clear_regs_i, ctrl_enable_regs_i, hit_i, trans_i, miss_i;
  logic [NB_BANKS-1:0][31:0] bank_hit_count_o, bank_trans_count_o, bank_miss_count_o;
  logic [31:0] global_hit_count_o, global_trans_count_o, global_miss_count_o;

  mp_icache_ctrl_responder #(
    .NB_BANKS(NB_BANKS), .NB_WAYS(NB_WAYS), .NB_SETS(NB_SETS), .LINE_BYTES(LINE_BYTES)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .bypass_req_i(bypass_req_i), .bypass_ack_o(bypass_ack_o),
    .bank_idle_i(bank_idle_i), .refill_idle_i(refill_idle_i),
    .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o),
    .sel_flush_req_i(sel_flush_req_i), .sel_flush_addr_i(sel_flush_addr_i),
    .sel_flush_ack_o(sel_flush_ack_o), .stall_o(stall_o),
    .tag_req_o(tag_req_o), .tag_we_o(tag_we_o), .tag_addr_o(tag_addr_o),
    .tag_way_be_o(tag_way_be_o), .tag_wdata_o(tag_wdata_o), .tag_rdata_i(tag_rdata_i),
    .ctrl_clear_regs_i(ctrl_clear_regs_i), .ctrl_enable_regs_i(ctrl_enable_regs_i),
    .hit_i(hit_i), .trans_i(trans_i), .miss_i(miss_i),
    .bank_hit_count_o(bank_hit_count_o), .bank_trans_count_o(bank_trans_count_o),
    .bank_miss_count_o(bank_miss_count_o),
    .global_hit_count_o(global_hit_count_o), .global_trans_count_o(global_trans_count_o),
    .global_miss_count_o(global_miss_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Tag array: 1-cycle read latency, masked writes, access log.
  logic [TAG_W:0] mem [NB_SETS][NB_WAYS];
  int cyc = 0;
  int wr_set[$], wr_be[$], wr_cyc[$], rd_set[$];

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (tag_req_o) begin
      if (tag_we_o) begin
        for (int w = 0; w < NB_WAYS; w++)
          if (tag_way_be_o[w]) mem[tag_addr_o][w] = tag_wdata_o;
        wr_set.push_back(int'(tag_addr_o));
        wr_be.push_back(int'(tag_way_be_o));
        wr_cyc.push_back(cyc);
      end else begin
        for (int w = 0; w < NB_WAYS; w++) tag_rdata_i[w] <= mem[tag_addr_o][w];
        rd_set.push_back(int'(tag_addr_o));
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_logs();
    wr_set.delete(); wr_be.delete(); wr_cyc.delete(); rd_set.delete();
  endtask

  function automatic logic [NB_WAYS-1:0] ref_mask(input logic [31:0] addr);
    logic [NB_WAYS-1:0] m;
    int s;
    s = int'(addr[OFF_W +: SET_W]);
    m = '0;
    for (int w = 0; w < NB_WAYS; w++)
      m[w] = mem[s][w][TAG_W] && (mem[s][w][TAG_W-1:0] == addr[31:OFF_W+SET_W]);
    return m;
  endfunction

  task automatic sel_flush(input logic [31:0] addr, input logic [NB_WAYS-1:0] exp_mask, input string tag);
    int acks;
    int s;
    acks = 0;
    s = int'(addr[OFF_W +: SET_W]);
    clear_logs();
    sel_flush_addr_i = addr;
    sel_flush_req_i  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 0) sel_flush_addr_i = $urandom;
      if (sel_flush_ack_o) acks++;
    end
    check_eq({tag, "_acks"}, acks, 1);
    check_eq({tag, "_stall_held"}, stall_o, 1'b1);
    check_eq({tag, "_reads"}, rd_set.size(), 1);
    if (rd_set.size() > 0) check_eq({tag, "_rd_set"}, rd_set[0], s);
    check_eq({tag, "_writes"}, wr_set.size(), (exp_mask != 0) ? 1 : 0);
    if (wr_set.size() > 0) begin
      check_eq({tag, "_wr_set"}, wr_set[0], s);
      check_eq({tag, "_wr_be"}, wr_be[0], exp_mask);
    end
    sel_flush_req_i = 1'b0;
    step(); step();
    check_eq({tag, "_stall_released"}, stall_o, 1'b0);
  endtask

  // Statistics reference: per-bank and global counters following the clear/enable rules.
  logic [31:0] e_hit[NB_BANKS], e_trn[NB_BANKS], e_mis[NB_BANKS];
  logic [31:0] e_ghit = 0, e_gtrn = 0, e_gmis = 0;

  task automatic stat_cycle(input logic [3:0] en, input logic [3:0] clr,
                            input logic [3:0] h, input logic [3:0] t, input logic [3:0] m);
    ctrl_enable_regs_i = en; ctrl_clear_regs_i = clr; hit_i = h; trans_i = t; miss_i = m;
    for (int b = 0; b < NB_BANKS; b++) begin
      if (clr[b]) begin
        e_hit[b] = 0; e_trn[b] = 0; e_mis[b] = 0;
      end else if (en[b]) begin
        e_hit[b] += 32'(h[b]); e_trn[b] += 32'(t[b]); e_mis[b] += 32'(m[b]);
      end
    end
    if (clr != 0) begin
      e_ghit = 0; e_gtrn = 0; e_gmis = 0;
    end else begin
      e_ghit += 32'($countones(h & en));
      e_gtrn += 32'($countones(t & en));
      e_gmis += 32'($countones(m & en));
    end
    step();
    hit_i = '0; trans_i = '0; miss_i = '0; ctrl_clear_regs_i = '0;
    for (int b = 0; b < NB_BANKS; b++) begin
      check_eq($sformatf("bank%0d_hit", b), bank_hit_count_o[b], e_hit[b]);
      check_eq($sformatf("bank%0d_trans", b), bank_trans_count_o[b], e_trn[b]);
      check_eq($sformatf("bank%0d_miss", b), bank_miss_count_o[b], e_mis[b]);
    end
    check_eq("global_hit", global_hit_count_o, e_ghit);
    check_eq("global_trans", global_trans_count_o, e_gtrn);
    check_eq("global_miss", global_miss_count_o, e_gmis);
  endtask

  initial begin
    logic [NB_BANKS:0] exp_byp;
    logic [NB_BANKS:0] idle_r;
    logic [31:0] addr;
    logic [TAG_W-1:0] tg;
    int k, seq_err, valid_left, s;

    bypass_req_i = 1'b1; bank_idle_i = '1; refill_idle_i = 1'b1;
    flush_req_i = 1'b0; sel_flush_req_i = 1'b0; sel_flush_addr_i = '0;
    ctrl_clear_regs_i = '0; ctrl_enable_regs_i = '0; hit_i = '0; trans_i = '0; miss_i = '0;
    tag_rdata_i = '0;
    for (int b = 0; b < NB_BANKS; b++) begin e_hit[b] = 0; e_trn[b] = 0; e_mis[b] = 0; end
    for (int i = 0; i < NB_SETS; i++)
      for (int w = 0; w < NB_WAYS; w++) mem[i][w] = (TAG_W+1)'($urandom);

    repeat (2) step();
    rst_ni = 1'b1;
    step();
    check_eq("rst_bypass_ack", bypass_ack_o, 5'h1F);
    check_eq("rst_flush_ack", flush_ack_o, 1'b0);
    check_eq("rst_stall", stall_o, 1'b0);
    check_eq("rst_tag_req", tag_req_o, 1'b0);
    check_eq("rst_sel_ack", sel_flush_ack_o, 1'b0);
    check_eq("rst_global_hit", global_hit_count_o, 0);
    check_eq("rst_bank3_miss", bank_miss_count_o[3], 0);

    // Bypass release: busy bank 2 holds its bit until it goes idle.
    bypass_req_i = 1'b0; bank_idle_i = 4'b1011; refill_idle_i = 1'b1;
    step();
    check_eq("byp_partial", bypass_ack_o, 5'b00100);
    bank_idle_i = 4'b1111;
    step();
    check_eq("byp_converged", bypass_ack_o, 5'b00000);

    exp_byp = '0;
    for (int i = 0; i < 200; i++) begin
      bypass_req_i = ($urandom_range(0, 3) != 0) ? ~bypass_req_i : bypass_req_i;
      idle_r = (NB_BANKS+1)'($urandom);
      {refill_idle_i, bank_idle_i} = idle_r;
      for (int b = 0; b <= NB_BANKS; b++) if (idle_r[b]) exp_byp[b] = bypass_req_i;
      step();
      check_eq("byp_random", bypass_ack_o, exp_byp);
    end
    bypass_req_i = 1'b0; bank_idle_i = '1; refill_idle_i = 1'b1;
    step();
    check_eq("byp_final", bypass_ack_o, 5'b00000);

    // Full flush with a busy bank during drain.
    clear_logs();
    flush_req_i = 1'b1; bank_idle_i = 4'b0111;
    step();
    check_eq("flush_stall_plus1", stall_o, 1'b1);
    repeat (3) step();
    check_eq("drain_no_write", wr_set.size(), 0);
    check_eq("drain_stall", stall_o, 1'b1);
    bank_idle_i = '1;
    k = 0;
    while (!flush_ack_o && k < 200) begin step(); k++; end
    check_eq("flush_ack_seen", flush_ack_o, 1'b1);
    check_eq("flush_write_count", wr_set.size(), NB_SETS);
    seq_err = 0;
    for (int i = 0; i < wr_set.size(); i++)
      if (wr_set[i] != i || wr_be[i] != 4'hF) seq_err++;
    check_eq("flush_write_seq", seq_err, 0);
    if (wr_set.size() == NB_SETS) check_eq("flush_contiguous", wr_cyc[NB_SETS-1] - wr_cyc[0], NB_SETS - 1);
    valid_left = 0;
    for (int i = 0; i < NB_SETS; i++)
      for (int w = 0; w < NB_WAYS; w++) if (mem[i][w][TAG_W]) valid_left++;
    check_eq("flush_all_invalid", valid_left, 0);
    check_eq("flush_done_stall", stall_o, 1'b0);
    repeat (4) step();
    check_eq("flush_ack_hold", flush_ack_o, 1'b1);
    check_eq("flush_no_extra_write", wr_set.size(), NB_SETS);
    flush_req_i = 1'b0;
    step();
    check_eq("flush_ack_drop", flush_ack_o, 1'b0);
    check_eq("flush_idle_stall", stall_o, 1'b0);

    // Selective flush: directed hit, directed miss, then random.
    for (int w = 0; w < NB_WAYS; w++) mem[5][w] = {1'b1, 22'h12345 ^ 22'(w + 1)};
    mem[5][2] = {1'b1, 22'h12345};
    sel_flush((32'h12345 << 10) | (32'd5 << 4), 4'b0100, "sel_hit");
    sel_flush((32'h3ABCD << 10) | (32'd5 << 4) | 32'h7, 4'b0000, "sel_miss");
    for (int it = 0; it < 8; it++) begin
      s  = $urandom_range(0, NB_SETS - 1);
      tg = TAG_W'($urandom);
      for (int w = 0; w < NB_WAYS; w++)
        mem[s][w] = ($urandom_range(0, 1) != 0) ? {1'($urandom), tg} : (TAG_W+1)'($urandom);
      addr = {tg, 6'(s), 4'($urandom)};
      sel_flush(addr, ref_mask(addr), $sformatf("sel_rand%0d", it));
    end

    // Simultaneous requests: full flush first, selective flush after the flush handshake.
    mem[9][1] = {1'b1, 22'h0ABCD};
    clear_logs();
    flush_req_i = 1'b1; sel_flush_req_i = 1'b1;
    sel_flush_addr_i = (32'h0ABCD << 10) | (32'd9 << 4);
    k = 0;
    s = 0;
    while (!flush_ack_o && k < 200) begin
      step(); k++;
      if (sel_flush_ack_o) s++;
    end
    check_eq("both_flush_ack", flush_ack_o, 1'b1);
    check_eq("both_no_sel_ack_yet", s, 0);
    check_eq("both_flush_writes", wr_set.size(), NB_SETS);
    check_eq("both_no_reads_yet", rd_set.size(), 0);
    flush_req_i = 1'b0;
    s = 0;
    for (int i = 0; i < 20; i++) begin step(); if (sel_flush_ack_o) s++; end
    check_eq("both_sel_ack", s, 1);
    check_eq("both_sel_reads", rd_set.size(), 1);
    if (rd_set.size() > 0) check_eq("both_sel_rd_set", rd_set[0], 9);
    check_eq("both_sel_no_write", wr_set.size(), NB_SETS);
    sel_flush_req_i = 1'b0;
    step(); step();
    check_eq("both_idle_stall", stall_o, 1'b0);

    // Statistics: directed bank-1 sequence, then random traffic.
    stat_cycle(4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    stat_cycle(4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    stat_cycle(4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    check_eq("bank1_hit_two", bank_hit_count_o[1], 2);
    check_eq("global_hit_two", global_hit_count_o, 2);
    stat_cycle(4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    check_eq("bank1_hit_cleared", bank_hit_count_o[1], 0);
    check_eq("global_hit_cleared", global_hit_count_o, 0);
    stat_cycle(4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b1111);
    check_eq("disabled_no_count", global_trans_count_o, 0);
    for (int i = 0; i < 300; i++)
      stat_cycle(4'($urandom), ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000,
                 4'($urandom), 4'($urandom), 4'($urandom));

    // Reset in the middle of a flush walk.
    bank_idle_i = '1; refill_idle_i = 1'b1; bypass_req_i = 1'b0;
    stat_cycle(4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
    clear_logs();
    flush_req_i = 1'b1;
    k = 0;
    while (!(tag_req_o && tag_we_o) && k < 50) begin step(); k++; end
    check_eq("walk_started", tag_we_o, 1'b1);
    repeat (10) step();
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("midrst_flush_ack", flush_ack_o, 1'b0);
    check_eq("midrst_stall", stall_o, 1'b0);
    check_eq("midrst_tag_req", tag_req_o, 1'b0);
    check_eq("midrst_bypass", bypass_ack_o, 5'h1F);
    check_eq("midrst_global_hit", global_hit_count_o, 0);
    flush_req_i = 1'b0;
    k = wr_set.size();
    repeat (2) step();
    rst_ni = 1'b1;
    repeat (3) step();
    check_eq("postrst_no_write", wr_set.size(), k);
    check_eq("postrst_flush_ack", flush_ack_o, 1'b0);
    check_eq("postrst_stall", stall_o, 1'b0);
    check_eq("postrst_bypass", bypass_ack_o, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
